// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits directly upstream of the main control
// decoder. It holds the PC and issues one memory request at a time over a
// valid/ready handshake. It captures the returned word and presents its decode
// fields (opcode, func3, func7 bit). The next PC is chosen from the decoder's
// pc_sel/branch_target pair. The unit also counts consumed instructions and
// latches a sticky error when a redirect target is misaligned.
//
// One instruction moves through REQ -> WAIT -> ISSUE. With zero memory wait
// states and no stall this gives one instruction every three cycles.
//
// Parameters
//   XLEN      width of PC, addresses and instruction word
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk             system clock; all state updates on its rising edge
//   reset           asynchronous, active-high reset
//   imem_req_valid  fetch request valid (held until imem_req_ready)
//   imem_req_ready  memory accepts the request this cycle
//   imem_addr       fetch address; pc while imem_req_valid=1, otherwise 0
//   imem_rsp_valid  response word valid (only honoured while waiting)
//   imem_rdata      response instruction word
//   stall           downstream not ready; hold the current instruction
//   pc_sel          1 = next PC is branch_target
//   branch_target   redirect address from decoder/ALU
//   inst_valid      inst/inst_pc/decode fields valid
//   inst            registered instruction word
//   inst_pc         PC of inst
//   opcode          inst[6:0]
//   func3           inst[14:12]
//   func7           inst[30]
//   instret         count of instructions consumed (wraps)
//   fetch_err       sticky misaligned-redirect error, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [31:0]     instret,
  output logic            fetch_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ISSUE,
    ERR
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            misaligned_redirect;

  // A redirect is only legal to a word-aligned target.
  assign misaligned_redirect = pc_sel && (branch_target[1:0] != 2'b00);

  // The address bus is quiet whenever no request is being offered. It is
  // derived from registered state only, so it stays glitch-free and stable
  // for as long as the request is held.
  assign imem_addr = imem_req_valid ? pc : '0;

  // Decode fields are plain slices of the instruction register. They are
  // therefore zero after reset and frozen while the instruction is held.
  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[30];

  // NOTE: every register in this block, including the outputs, uses
  // non-blocking assignment. Each branch then reads the pre-edge values of
  // pc/instret/state, with no ordering hazards between statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      instret        <= '0;
      fetch_err      <= 1'b0;
    end else begin
      case (state)
        // One quiet cycle after reset release before the first request.
        IDLE: begin
          imem_req_valid <= 1'b1;
          state          <= REQ;
        end

        // Request is held, with a stable address, until the memory takes it.
        REQ: begin
          if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end

        // Exactly one request is outstanding here. Responses in any other
        // state (including stale ones from before a reset) are dropped.
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= ISSUE;
          end
        end

        // Instruction is presented. Redirect inputs are only sampled in the
        // cycle the decoder consumes it (stall low).
        ISSUE: begin
          if (!stall) begin
            instret    <= instret + 32'd1;
            inst_valid <= 1'b0;
            if (misaligned_redirect) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              pc             <= pc_sel ? branch_target : pc + XLEN'(4);
              imem_req_valid <= 1'b1;
              state          <= REQ;
            end
          end
        end

        // Terminal until reset: no requests, nothing valid, error held.
        ERR: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          fetch_err      <= 1'b1;
        end

        default: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. The bench plays the instruction memory
// and the decoder. It keeps a transaction-level model of the architectural
// state (expected next fetch PC, retired count, error flag). For each fetch it
// checks the handshake, the captured word and decode fields, the hold
// behaviour under stall, and the next PC that follows from pc_sel.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic [31:0] instret;
  logic        fetch_err;

  fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .branch_target  (branch_target),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7),
    .instret        (instret),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state the fetch unit must expose.
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    stall          = 1'b0;
    pc_sel         = 1'b0;
    branch_target  = '0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
    check({tag, "_addr"},       imem_addr,           32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid),     32'd0);
    check({tag, "_inst"},       inst,                32'd0);
    check({tag, "_inst_pc"},    inst_pc,             32'd0);
    check({tag, "_opcode"},     32'(opcode),         32'd0);
    check({tag, "_func3"},      32'(func3),          32'd0);
    check({tag, "_func7"},      32'(func7),          32'd0);
    check({tag, "_instret"},    instret,             32'd0);
    check({tag, "_fetch_err"},  32'(fetch_err),      32'd0);
  endtask

  // Assert reset away from the clock edge, confirm the clear is immediate
  // (asynchronous), hold it two edges, then release.
  task automatic apply_reset(input logic rsp_during_reset);
    idle_inputs();
    reset          = 1'b1;
    imem_rsp_valid = rsp_during_reset;
    imem_rdata     = 32'hDEAD_BEEF;
    #1;
    check_cleared("reset");
    tick();
    tick();
    reset       = 1'b0;
    exp_pc      = RESET_PC;
    exp_instret = 32'd0;
    check("idle_req_valid",  32'(imem_req_valid), 32'd0);
    check("idle_inst_valid", 32'(inst_valid),     32'd0);
  endtask

  // A misaligned redirect leaves the unit silent until reset.
  task automatic check_err_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("err_sticky",     32'(fetch_err),      32'd1);
      check("err_req_valid",  32'(imem_req_valid), 32'd0);
      check("err_inst_valid", 32'(inst_valid),     32'd0);
      check("err_addr",       imem_addr,           32'd0);
    end
  endtask

  // One full fetch transaction, from request offer through decoder consumption.
  //   rdy_dly : cycles imem_req_ready is held low before acceptance
  //   rsp_dly : extra cycles in WAIT before the response
  //   stall_n : cycles of stall in ISSUE (st_sel/st_tgt driven meanwhile)
  //   sel/tgt : redirect presented in the consuming cycle
  task automatic do_fetch(input int rdy_dly, input int rsp_dly, input int stall_n,
                          input logic st_sel, input logic [31:0] st_tgt,
                          input logic sel, input logic [31:0] tgt,
                          input logic [31:0] word, output logic err);
    int n;
    n   = 0;
    err = 1'b0;
    while (imem_req_valid !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr",  imem_addr,           exp_pc);

    // Memory not ready: request must stay up with a stable address, and
    // stray responses must be ignored.
    imem_req_ready = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      imem_rsp_valid = 1'($urandom);
      imem_rdata     = $urandom;
      tick();
      check("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check("req_hold_addr",  imem_addr,           exp_pc);
      check("req_hold_inst_valid", 32'(inst_valid), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_addr",      imem_addr,           32'd0);

    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check("wait_inst_valid", 32'(inst_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rdata     = word;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rdata     = $urandom;
    check("issue_inst_valid", 32'(inst_valid), 32'd1);
    check("issue_inst",       inst,            word);
    check("issue_inst_pc",    inst_pc,         exp_pc);
    check("issue_opcode",     32'(opcode),     word & 32'h0000_007F);
    check("issue_func3",      32'(func3),      (word >> 12) & 32'h7);
    check("issue_func7",      32'(func7),      (word >> 30) & 32'h1);
    check("issue_instret",    instret,         exp_instret);

    // Stall: everything frozen, redirect inputs ignored, stray rsp ignored.
    for (int i = 0; i < stall_n; i++) begin
      stall          = 1'b1;
      pc_sel         = st_sel;
      branch_target  = st_tgt;
      imem_rsp_valid = 1'($urandom);
      tick();
      check("stall_inst_valid", 32'(inst_valid),     32'd1);
      check("stall_inst",       inst,                word);
      check("stall_inst_pc",    inst_pc,             exp_pc);
      check("stall_instret",    instret,             exp_instret);
      check("stall_req_valid",  32'(imem_req_valid), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    stall          = 1'b0;
    pc_sel         = sel;
    branch_target  = tgt;
    tick();
    pc_sel         = 1'b0;
    branch_target  = '0;

    exp_instret = exp_instret + 32'd1;
    check("consume_instret",    instret,         exp_instret);
    check("consume_inst_valid", 32'(inst_valid), 32'd0);
    if (sel && (tgt & 32'h3) != 32'd0) begin
      err = 1'b1;
      check("misalign_err",       32'(fetch_err),      32'd1);
      check("misalign_req_valid", 32'(imem_req_valid), 32'd0);
    end else begin
      exp_pc = sel ? tgt : exp_pc + 32'd4;
      check("next_req_valid", 32'(imem_req_valid), 32'd1);
      check("next_addr",      imem_addr,           exp_pc);
      check("next_fetch_err", 32'(fetch_err),      32'd0);
    end
  endtask

  initial begin
    logic        err;
    logic        sel;
    logic [31:0] tgt;

    idle_inputs();
    reset = 1'b1;
    apply_reset(1'b0);

    // First fetch, zero wait states, word 0x33 (add-like R-type).
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0033, err);

    // Two more sequential fetches -> addresses 4, 8; instret reaches 3.
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4000_5013, err);
    do_fetch(0, 1, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, err);
    check("instret_after_three", instret, 32'd3);

    // Memory not ready for 5 cycles.
    apply_reset(1'b0);
    do_fetch(5, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0063, err);

    // Stall 4 cycles with a distracting redirect, then consume with 0x40.
    do_fetch(0, 0, 4, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040, 32'h0020_8133, err);
    check("redirect_addr", imem_addr, 32'h0000_0040);

    // PC wrap: redirect to the last word, then fall through to address 0.
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0000_006F, err);
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0013, err);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Misaligned redirect -> sticky error, silent until reset.
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 32'h0000_0067, err);
    check("misalign_flag", 32'(err), 32'd1);
    check_err_quiet(5);
    apply_reset(1'b0);
    do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0033, err);

    // Reset while waiting, with a response driven during and just after reset.
    begin
      int n;
      n = 0;
      while (imem_req_valid !== 1'b1 && n < 4) begin
        tick();
        n++;
      end
      check("rst_wait_req_valid", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      apply_reset(1'b1);
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      check("rst_wait_inst_valid", 32'(inst_valid),     32'd0);
      check("rst_wait_req_valid2", 32'(imem_req_valid), 32'd1);
      check("rst_wait_addr",       imem_addr,           RESET_PC);
      do_fetch(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_1033, err);
    end

    // Randomized traffic against the model; occasional misaligned redirects.
    for (int t = 0; t < 60; t++) begin
      sel = 1'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), $urandom, sel, tgt, $urandom, err);
      if (err) begin
        check_err_quiet(2);
        apply_reset(1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
